// File: rtl/memory_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : memory_dump_sequencer
//  Brief    : Streams the written data-memory region (8-byte header of
//             start address and word count, then the words little-endian)
//             over a valid/ready byte interface for the debug link.
//  Revision : 1.0 - initial release
// ============================================================================
module memory_dump_sequencer #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        global_flush_i,
  input  logic        start_i,
  input  logic [31:0] min_addr_i,
  input  logic [31:0] max_addr_i,
  output logic        mem_re_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  // Byte address of the last word in data memory.
  localparam logic [31:0] c_last_addr = 32'(DMEM_WORDS * 4 - 4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCH   = 3'd1,
    S_HDR     = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_SEND    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_min;
  logic [31:0] r_max;
  logic [31:0] r_addr;       // holds the start address during the header
  logic [31:0] r_remaining;  // holds the word count during the header
  logic [31:0] r_word;
  logic [2:0]  r_idx;        // byte index within header (0..7) or word (0..3)

  logic [31:0] w_start;
  logic [31:0] w_max_al;
  logic [31:0] w_end;
  logic        w_empty;
  logic [31:0] w_count;
  logic [63:0] w_hdr;

  // Dump range derived from the sampled tracker pair; end is clamped to memory.
  always_comb begin
    w_start  = {r_min[31:2], 2'b00};
    w_max_al = {r_max[31:2], 2'b00};
    w_end    = (w_max_al > c_last_addr) ? c_last_addr : w_max_al;
    w_empty  = (r_min > r_max) || (w_start > c_last_addr);
    w_count  = ((w_end - w_start) >> 2) + 32'd1;
    w_hdr    = {r_remaining, r_addr};
  end

  // State register; flush wins over everything, including a same-cycle start.
  always_ff @(posedge clk) begin
    if (global_flush_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and outputs; outputs depend only on state and registers so
  // tx_valid_o never follows tx_ready_i combinationally.
  always_comb begin
    w_next     = r_state;
    mem_re_o   = 1'b0;
    mem_addr_o = 32'd0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'd0;
    busy_o     = (r_state != S_IDLE);
    done_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_LATCH;
      end
      S_LATCH: begin
        w_next = S_HDR;
      end
      S_HDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = w_hdr[{r_idx, 3'b000} +: 8];
        if (tx_ready_i && (r_idx == 3'd7)) begin
          w_next = (r_remaining != 32'd0) ? S_RD_REQ : S_DONE;
        end
      end
      S_RD_REQ: begin
        mem_re_o   = 1'b1;
        mem_addr_o = r_addr;
        w_next     = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = r_word[{r_idx[1:0], 3'b000} +: 8];
        if (tx_ready_i && (r_idx[1:0] == 2'd3)) begin
          w_next = (r_remaining == 32'd1) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: range capture, address/count bookkeeping and byte indexing.
  always_ff @(posedge clk) begin
    if (global_flush_i) begin
      r_min       <= 32'd0;
      r_max       <= 32'd0;
      r_addr      <= 32'd0;
      r_remaining <= 32'd0;
      r_word      <= 32'd0;
      r_idx       <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_min <= min_addr_i;
            r_max <= max_addr_i;
          end
        end
        S_LATCH: begin
          r_addr      <= w_empty ? 32'd0 : w_start;
          r_remaining <= w_empty ? 32'd0 : w_count;
          r_idx       <= 3'd0;
        end
        S_HDR: begin
          if (tx_ready_i) r_idx <= r_idx + 3'd1;
        end
        S_RD_WAIT: begin
          r_word <= mem_rdata_i;
          r_idx  <= 3'd0;
        end
        S_SEND: begin
          if (tx_ready_i) begin
            if (r_idx[1:0] == 2'd3) begin
              r_idx       <= 3'd0;
              r_addr      <= r_addr + 32'd4;
              r_remaining <= r_remaining - 32'd1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/memory_dump_sequencer.md
# memory_dump_sequencer

Streams the data-memory region modified by the running program out as a byte stream for the debug link. At `start_i` it samples the min/max written-address pair produced by the memory range tracker. It then reads data memory one word at a time and emits an 8-byte header followed by the words, little-endian, over a valid/ready byte interface to the UART TX path. Unmodified memory is never dumped.

## Interface
- `DMEM_WORDS`, default 256: data memory depth in 32-bit words; valid byte addresses are 0 .. DMEM_WORDS*4-1.
- `clk` in 1: single clock, rising edge.
- `global_flush_i` in 1: synchronous, active-high reset/flush.
- `start_i` in 1: one-cycle request to begin a dump; ignored while `busy_o`=1.
- `min_addr_i` in 32: lowest written byte address (0xFFFF_FFFF when nothing was written).
- `max_addr_i` in 32: highest written byte address (0x0000_0000 when nothing was written).
- `mem_re_o` out 1: data memory read enable.
- `mem_addr_o` out 32: word-aligned byte address for the read.
- `mem_rdata_i` in 32: read data, valid exactly one cycle after `mem_re_o`.
- `tx_data_o` out 8: outgoing byte.
- `tx_valid_o` out 1: `tx_data_o` is valid.
- `tx_ready_i` in 1: sink accepts the byte when `tx_valid_o` and `tx_ready_i` are both 1.
- `busy_o` out 1: dump in progress (all states except IDLE).
- `done_o` out 1: one-cycle pulse when the last byte has been accepted.

## Operation
- FSM states: IDLE, LATCH, HDR, RD_REQ, RD_WAIT, SEND, DONE.
- IDLE: when `start_i`=1, register `min_addr_i` and `max_addr_i` and go to LATCH.
- LATCH computes the dump range:
  - start = min & ~3
  - end = min(max & ~3, DMEM_WORDS*4-4)
  - range is empty if min > max, or if start > DMEM_WORDS*4-4
  - if empty: start = 0, count = 0
  - otherwise: count = ((end-start)>>2)+1, a 32-bit unsigned value
  - go to HDR.
- HDR: send 8 bytes in order: start[7:0], [15:8], [23:16], [31:24], then count in the same byte order.
  - Then go to RD_REQ if count≠0, else DONE.
- RD_REQ: one cycle with `mem_re_o`=1 and `mem_addr_o`=current address. Go to RD_WAIT.
- RD_WAIT: capture `mem_rdata_i` into the word buffer. Go to SEND.
- SEND: send the word buffer bytes [7:0] first and [31:24] last.
  - After the 4th byte is accepted: address += 4 and remaining -= 1.
  - If remaining = 0 go to DONE, else go to RD_REQ.
- DONE: `done_o`=1 for one cycle, then IDLE.
- Handshake rules:
  - `tx_valid_o` is 1 only in HDR and SEND.
  - While `tx_valid_o`=1 and `tx_ready_i`=0, `tx_data_o` holds stable and `tx_valid_o` stays 1.
  - The byte index advances only on acceptance.
  - `tx_valid_o` never depends combinationally on `tx_ready_i`.
- `mem_re_o` is 1 only in RD_REQ. Memory is never read outside the computed range.
- Reset/flush: `global_flush_i`=1 in any state forces IDLE on the next edge.
  - All outputs read 0 after the edge: `tx_valid_o`, `tx_data_o`, `mem_re_o`, `mem_addr_o`, `busy_o`, `done_o`.
  - A flush mid-dump produces no `done_o` and drops the partial stream.
  - Flush takes priority over `start_i` in the same cycle.

## Timing
- `start_i` accepted at edge t0.
  - LATCH occupies cycle t0+1.
  - First header byte is valid in cycle t0+2.
- With `tx_ready_i` held at 1:
  - header occupies t0+2..t0+9
  - each word takes 6 cycles: RD_REQ, RD_WAIT, 4 bytes
  - last byte of an N-word dump is in cycle t0+9+6N
  - `done_o` is high in cycle t0+10+6N, with `busy_o`=1 in that cycle and 0 the next.
- Empty range: 8 header bytes (all zero), then `done_o` in t0+10.
- Each cycle with `tx_ready_i`=0 during HDR or SEND adds exactly one cycle. Stalls never occur in RD_REQ or RD_WAIT.
- The earliest new `start_i` is accepted in the cycle after DONE.

## Test plan
- min=0x10, max=0x18, `tx_ready_i`=1, memory words 0x11223344 / 0x55667788 / 0x99AABBCC:
  - bytes are 10 00 00 00 03 00 00 00 44 33 22 11 88 77 66 55 CC BB AA 99
  - `done_o` is high at t0+28.
- Unaligned min=0x13, max=0x15:
  - start=0x10, count=2
  - reads occur at 0x10 and 0x14 only.
- No writes (min=0xFFFF_FFFF, max=0):
  - 8 zero bytes, no `mem_re_o`
  - `done_o` is high at t0+10.
- max=0x2000 with DMEM_WORDS=256, min=0x3F8:
  - count=2 (0x3F8, 0x3FC).
- Random `tx_ready_i` backpressure at 30% duty:
  - byte stream is identical to the unstalled run
  - `tx_data_o` is stable during every stall
  - `start_i` pulses while busy are ignored.
- `global_flush_i` asserted mid-SEND:
  - next cycle: `tx_valid_o`=0, `busy_o`=0, no `done_o`
  - a subsequent `start_i` yields a complete, correct dump.
